// File: rtl/life_pkg.sv
// Shared types and constants for the 8x8 Game-of-Life controller and its datapath.
package life_pkg;

    localparam int GRID_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CHECK,
        ST_PAUSE,
        ST_DONE
    } state_t;

    typedef enum logic {
        MODE_STEP,
        MODE_RUN
    } mode_t;

    localparam logic [1:0] HALT_NONE    = 2'b00;
    localparam logic [1:0] HALT_EXTINCT = 2'b01;
    localparam logic [1:0] HALT_STILL   = 2'b10;
    localparam logic [1:0] HALT_MAXGEN  = 2'b11;

    // Cells outside the 8x8 board read as dead, so the board has no wraparound.
    function automatic logic cell_at(input logic [GRID_W-1:0] g, input int r, input int c);
        if (r < 0 || r > 7 || c < 0 || c > 7) begin
            return 1'b0;
        end
        return g[6'(r*8 + c)];
    endfunction

endpackage

// File: rtl/life_dp_shim.sv
// Wraps the evolution datapath with a req/ack handshake whose ack latency is set by i_lat.
module life_dp_shim
    import life_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [GRID_W-1:0] i_grid,
    input  logic [3:0]        i_lat,
    output logic              o_ack,
    output logic [GRID_W-1:0] o_evolved
);

    logic [GRID_W-1:0] w_evolved;
    logic [GRID_W-1:0] r_res;
    logic [3:0]        r_cnt;

    life_evolve u_evolve (
        .i_grid (i_grid),
        .o_grid (w_evolved)
    );

    // Ack fires i_lat cycles after the request; a latency of 0 is treated as 1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
            r_res <= '0;
        end else if (i_req) begin
            r_res <= w_evolved;
            r_cnt <= (i_lat == 4'd0) ? 4'd1 : i_lat;
        end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_ack     = (r_cnt == 4'd1);
    assign o_evolved = r_res;

endmodule

// File: rtl/life_evolve.sv
// Combinational one-generation Game-of-Life update on the 8x8 board (dead border).
module life_evolve
    import life_pkg::*;
(
    input  logic [GRID_W-1:0] i_grid,
    output logic [GRID_W-1:0] o_grid
);

    logic [3:0] w_n;

    always_comb begin
        o_grid = '0;
        w_n    = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                w_n = '0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            w_n = w_n + 4'(cell_at(i_grid, r + dr, c + dc));
                        end
                    end
                end
                o_grid[6'(r*8 + c)] = (w_n == 4'd3) || ((w_n == 4'd2) && cell_at(i_grid, r, c));
            end
        end
    end

endmodule

// File: rtl/life_ctrl.sv
// Sequences single-step or continuous Game-of-Life evolution through an external datapath,
// detecting extinction, still life and a generation limit.
module life_ctrl
    import life_pkg::*;
#(
    parameter int GEN_W = 16,
    parameter int PER_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [GRID_W-1:0] seed,
    input  logic              step,
    input  logic              run,
    input  logic              stop,
    input  logic [PER_W-1:0]  period,
    input  logic [GEN_W-1:0]  max_gen,
    output logic              dp_req,
    output logic [GRID_W-1:0] dp_grid,
    input  logic              dp_ack,
    input  logic [GRID_W-1:0] dp_evolved,
    output logic [GRID_W-1:0] grid,
    output logic [GEN_W-1:0]  gen_count,
    output logic              busy,
    output logic              done,
    output logic [1:0]        halt_cause
);

    state_t            r_state;
    state_t            w_next_state;
    mode_t             r_mode;
    logic              r_stop;
    logic [GRID_W-1:0] r_grid;
    logic [GRID_W-1:0] r_next;
    logic [GEN_W-1:0]  r_gen;
    logic [1:0]        r_halt;
    logic [PER_W-1:0]  r_cnt;

    logic              w_extinct;
    logic              w_still;
    logic              w_maxhit;
    logic [GEN_W-1:0]  w_gen_inc;

    assign w_gen_inc = (r_gen == '1) ? r_gen : r_gen + GEN_W'(1);
    assign w_extinct = (r_next == '0);
    assign w_still   = (r_next == r_grid);
    assign w_maxhit  = (max_gen != '0) && (w_gen_inc == max_gen);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (!load && (run || step)) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (dp_ack) begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_extinct || w_still || w_maxhit) begin
                    w_next_state = ST_DONE;
                end else if (r_stop || (r_mode == MODE_STEP)) begin
                    w_next_state = ST_IDLE;
                end else if (period == '0) begin
                    w_next_state = ST_ISSUE;
                end else begin
                    w_next_state = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    w_next_state = ST_IDLE;
                end else if (r_cnt <= PER_W'(1)) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_DONE: begin
                if (load || stop) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        dp_req = (r_state == ST_ISSUE);
        busy   = (r_state != ST_IDLE) && (r_state != ST_DONE);
        done   = (r_state == ST_DONE);
    end

    // The pause counter is loaded in CHECK so PAUSE lasts exactly 'period' cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mode <= MODE_STEP;
            r_stop <= 1'b0;
            r_grid <= '0;
            r_next <= '0;
            r_gen  <= '0;
            r_halt <= HALT_NONE;
            r_cnt  <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_stop <= 1'b0;
                    if (load) begin
                        r_grid <= seed;
                        r_gen  <= '0;
                        r_halt <= HALT_NONE;
                    end else if (run) begin
                        r_mode <= MODE_RUN;
                    end else if (step) begin
                        r_mode <= MODE_STEP;
                    end
                end
                ST_ISSUE: begin
                    if (stop) r_stop <= 1'b1;
                end
                ST_WAIT: begin
                    if (stop) r_stop <= 1'b1;
                    if (dp_ack) r_next <= dp_evolved;
                end
                ST_CHECK: begin
                    r_grid <= r_next;
                    r_gen  <= w_gen_inc;
                    r_cnt  <= period;
                    if (w_extinct) begin
                        r_halt <= HALT_EXTINCT;
                    end else if (w_still) begin
                        r_halt <= HALT_STILL;
                    end else if (w_maxhit) begin
                        r_halt <= HALT_MAXGEN;
                    end
                end
                ST_PAUSE: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - PER_W'(1);
                end
                ST_DONE: begin
                    if (load) begin
                        r_grid <= seed;
                        r_gen  <= '0;
                        r_halt <= HALT_NONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dp_grid    = r_grid;
    assign grid       = r_grid;
    assign gen_count  = r_gen;
    assign halt_cause = r_halt;

endmodule

// File: tb/tb_life_ctrl.sv
// Directed bench for life_ctrl with a scoreboard of expected generations and a reference Life model.
module tb_life_ctrl;
    import life_pkg::*;

    localparam logic [63:0] BLINKER  = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLINK_H  = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLOCK    = 64'h0000_0018_1800_0000;
    localparam logic [63:0] SINGLE   = 64'h0000_0000_0800_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0, step = 1'b0, run = 1'b0, stop = 1'b0;
    logic [63:0] seed = '0;
    logic [23:0] period = '0;
    logic [15:0] max_gen = '0;
    logic        dp_req, dp_ack, busy, done;
    logic [63:0] dp_grid, dp_evolved, grid;
    logic [15:0] gen_count;
    logic [1:0]  halt_cause;
    logic        shim_rst_n = 1'b1;
    logic [3:0]  lat = 4'd1;

    typedef struct packed {
        logic [63:0] grid;
        logic [15:0] gen;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0, req_cnt = 0, req_last = 0, req_prev = 0;
    logic [15:0] prev_gen = '0;

    life_ctrl #(.GEN_W(16), .PER_W(24)) dut (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .step(step), .run(run),
        .stop(stop), .period(period), .max_gen(max_gen), .dp_req(dp_req),
        .dp_grid(dp_grid), .dp_ack(dp_ack), .dp_evolved(dp_evolved), .grid(grid),
        .gen_count(gen_count), .busy(busy), .done(done), .halt_cause(halt_cause)
    );

    life_dp_shim u_shim (
        .clk(clk), .reset(shim_rst_n), .i_req(dp_req), .i_grid(dp_grid),
        .i_lat(lat), .o_ack(dp_ack), .o_evolved(dp_evolved)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic logic [63:0] ref_gen(input logic [63:0] g);
        logic b [0:9][0:9];
        logic [63:0] res;
        int n;
        res = '0;
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++) b[r][c] = 1'b0;
        for (int i = 0; i < 64; i++) b[i/8 + 1][i%8 + 1] = g[i];
        for (int r = 1; r <= 8; r++) begin
            for (int c = 1; c <= 8; c++) begin
                n = int'(b[r-1][c-1]) + int'(b[r-1][c]) + int'(b[r-1][c+1]) +
                    int'(b[r][c-1])                     + int'(b[r][c+1]) +
                    int'(b[r+1][c-1]) + int'(b[r+1][c]) + int'(b[r+1][c+1]);
                res[(r-1)*8 + (c-1)] = (n == 3) || (n == 2 && b[r][c]);
            end
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dp_req === 1'b1) begin
            req_cnt  <= req_cnt + 1;
            req_prev <= req_last;
            req_last <= cyc;
        end
    end

    // Each completed generation pops one expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && gen_count !== prev_gen && gen_count !== 16'd0) begin
            e = '0;
            if (sb_q.size() != 0) e = sb_q.pop_front();
            chk("sb_grid", grid, e.grid);
            chk("sb_gen", 64'(gen_count), 64'(e.gen));
        end
        prev_gen <= gen_count;
    end

    task automatic do_load(input logic [63:0] s);
        @(negedge clk); seed = s; load = 1'b1;
        @(negedge clk); load = 1'b0;
    endtask

    task automatic do_step();
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
    endtask

    task automatic do_run(input logic [23:0] p, input logic [15:0] mg);
        @(negedge clk); period = p; max_gen = mg; run = 1'b1;
        @(negedge clk); run = 1'b0;
    endtask

    task automatic do_stop();
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(busy), 64'd0);
    endtask

    task automatic push_gens(input logic [63:0] s, input int count);
        logic [63:0] g = s;
        for (int i = 1; i <= count; i++) begin
            g = ref_gen(g);
            sb_q.push_back('{grid: g, gen: 16'(i)});
        end
    endtask

    initial begin
        int n, base;
        // Reset values
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_grid", grid, 64'd0);
        chk("rst_gen", 64'(gen_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_halt", 64'(halt_cause), 64'd0);
        chk("rst_dp_req", 64'(dp_req), 64'd0);
        reset = 1'b1;

        // Single step of a vertical blinker, 1-cycle datapath
        lat = 4'd1;
        do_load(BLINKER);
        chk("load_grid", grid, BLINKER);
        chk("model_blinker", ref_gen(BLINKER), BLINK_H);
        push_gens(BLINKER, 1);
        do_step();
        n = 1;
        while (gen_count !== 16'd1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("step_latency", 64'(n), 64'd4);
        wait_quiet("step_busy_falls", 50);
        chk("step_grid", grid, BLINK_H);
        chk("step_gen", 64'(gen_count), 64'd1);
        chk("step_done", 64'(done), 64'd0);

        // Blinker run to max_gen=4, back-to-back generations
        do_load(BLINKER);
        base = req_cnt;
        push_gens(BLINKER, 4);
        do_run(24'd0, 16'd4);
        wait_quiet("run4_quiet", 200);
        chk("run4_reqs", 64'(req_cnt - base), 64'd4);
        chk("run4_grid", grid, BLINKER);
        chk("run4_done", 64'(done), 64'd1);
        chk("run4_halt", 64'(halt_cause), 64'(HALT_MAXGEN));
        chk("run4_gen", 64'(gen_count), 64'd4);
        base = req_cnt;
        do_step();
        repeat (6) @(negedge clk);
        chk("done_ignores_step", 64'(req_cnt - base), 64'd0);
        chk("done_holds", 64'(done), 64'd1);
        do_stop();
        chk("done_stop_exit", 64'(done), 64'd0);
        chk("done_stop_halt", 64'(halt_cause), 64'(HALT_MAXGEN));
        chk("done_stop_gen", 64'(gen_count), 64'd4);

        // Block: still life after one generation
        do_load(BLOCK);
        chk("load_clears_halt", 64'(halt_cause), 64'd0);
        push_gens(BLOCK, 1);
        do_run(24'd0, 16'd0);
        wait_quiet("block_quiet", 200);
        chk("block_done", 64'(done), 64'd1);
        chk("block_halt", 64'(halt_cause), 64'(HALT_STILL));
        chk("block_gen", 64'(gen_count), 64'd1);

        // Single cell dies; load is accepted straight from DONE
        do_load(SINGLE);
        chk("reload_done", 64'(done), 64'd0);
        chk("reload_gen", 64'(gen_count), 64'd0);
        push_gens(SINGLE, 1);
        do_step();
        wait_quiet("single_quiet", 200);
        chk("single_grid", grid, 64'd0);
        chk("single_halt", 64'(halt_cause), 64'(HALT_EXTINCT));
        chk("single_done", 64'(done), 64'd1);

        // Run with period=5 and 3-cycle ack; stop lands in WAIT of the 2nd generation
        lat = 4'd3;
        do_load(BLINKER);
        push_gens(BLINKER, 2);
        base = req_cnt;
        do_run(24'd5, 16'd0);
        n = 0;
        while (req_cnt < base + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("period_second_req", 64'(req_cnt - base), 64'd2);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        // ISSUE + 3 WAIT + CHECK + 5 PAUSE cycles between requests
        chk("period_interval", 64'(req_last - req_prev), 64'd10);
        wait_quiet("stop_quiet", 200);
        repeat (20) @(negedge clk);
        chk("stop_no_more_req", 64'(req_cnt - base), 64'd2);
        chk("stop_gen", 64'(gen_count), 64'd2);
        chk("stop_grid", grid, BLINKER);
        chk("stop_done", 64'(done), 64'd0);

        // Reset while waiting on the datapath; the late ack must be ignored
        do_load(BLINKER);
        base = req_cnt;
        do_run(24'd0, 16'd0);
        n = 0;
        while (req_cnt < base + 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        chk("mid_rst_grid", grid, 64'd0);
        chk("mid_rst_gen", 64'(gen_count), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_halt", 64'(halt_cause), 64'd0);
        chk("mid_rst_reqs", 64'(req_cnt - base), 64'd1);

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
